// File: rtl/dma_desc_sched.sv
// Descriptor scheduler: round-robin walk over enabled slots, one command in flight.
// Optional DMA_SCHED_ERR_STOP_EN: an errored completion ends the run early.
module dma_desc_sched #(
  parameter int NUM_DESC = 2,
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 32,
  localparam int IDW     = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go_i,
  input  logic                       abort_i,
  input  logic [NUM_DESC-1:0]        desc_en_i,
  input  logic [NUM_DESC*ADDR_W-1:0] desc_src_i,
  input  logic [NUM_DESC*ADDR_W-1:0] desc_dst_i,
  input  logic [NUM_DESC*LEN_W-1:0]  desc_len_i,
  output logic                       cmd_valid_o,
  input  logic                       cmd_ready_i,
  output logic [ADDR_W-1:0]          cmd_src_o,
  output logic [ADDR_W-1:0]          cmd_dst_o,
  output logic [LEN_W-1:0]           cmd_len_o,
  output logic [IDW-1:0]             cmd_id_o,
  input  logic                       cpl_valid_i,
  input  logic                       cpl_err_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [NUM_DESC-1:0]        desc_done_o,
  output logic [NUM_DESC-1:0]        desc_err_o
);

`ifdef DMA_SCHED_ERR_STOP_EN
  localparam bit ERR_STOP = 1'b1;
`else
  localparam bit ERR_STOP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  state_t              state_q;
  logic [NUM_DESC-1:0] pend_q;
  logic [IDW-1:0]      ptr_q;
  logic                abort_q;
  logic                cmd_valid_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [LEN_W-1:0]    len_q;
  logic [IDW-1:0]      id_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [NUM_DESC-1:0] ddone_q;
  logic [NUM_DESC-1:0] derr_q;

  logic                pick_hit;
  logic [IDW-1:0]      pick_idx;
  logic [IDW-1:0]      cand;
  logic [LEN_W-1:0]    pick_len;
  logic [ADDR_W-1:0]   pick_src;
  logic [ADDR_W-1:0]   pick_dst;
  logic [IDW-1:0]      ptr_nxt;
  logic                stop_w;
  int                  j;

  // first pending slot at or after the pointer, wrapping
  always_comb begin
    pick_hit = 1'b0;
    pick_idx = '0;
    cand     = '0;
    j        = 0;
    for (int k = 0; k < NUM_DESC; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_DESC) j = j - NUM_DESC;
      cand = IDW'(j);
      if (!pick_hit && pend_q[cand]) begin
        pick_hit = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // descriptor fields of the picked slot and completion bookkeeping
  always_comb begin
    pick_len = desc_len_i[int'(pick_idx)*LEN_W +: LEN_W];
    pick_src = desc_src_i[int'(pick_idx)*ADDR_W +: ADDR_W];
    pick_dst = desc_dst_i[int'(pick_idx)*ADDR_W +: ADDR_W];
    ptr_nxt  = (int'(id_q) == NUM_DESC - 1) ? '0 : id_q + 1'b1;
    stop_w   = abort_q | abort_i | (ERR_STOP & cpl_err_i);
  end

  // scheduler FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      ptr_q       <= '0;
      abort_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      id_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ddone_q     <= '0;
      derr_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (go_i) begin
            pend_q  <= desc_en_i;
            ddone_q <= '0;
            derr_q  <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b1;
            if (desc_en_i == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ARB;
            end
          end
        end
        S_ARB: begin
          if (abort_i || !pick_hit) begin
            pend_q  <= '0;
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end else if (pick_len == '0) begin
            ddone_q[pick_idx] <= 1'b1;
            pend_q[pick_idx]  <= 1'b0;
          end else begin
            src_q       <= pick_src;
            dst_q       <= pick_dst;
            len_q       <= pick_len;
            id_q        <= pick_idx;
            cmd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready_i) begin
            cmd_valid_q <= 1'b0;
            abort_q     <= abort_i;
            state_q     <= S_WAIT;
          end else if (abort_i) begin
            cmd_valid_q <= 1'b0;
            pend_q      <= '0;
            state_q     <= S_FIN;
            done_q      <= 1'b1;
          end
        end
        S_WAIT: begin
          if (abort_i) abort_q <= 1'b1;
          if (cpl_valid_i) begin
            ddone_q[id_q] <= 1'b1;
            pend_q[id_q]  <= 1'b0;
            ptr_q         <= ptr_nxt;
            if (cpl_err_i) begin
              derr_q[id_q] <= 1'b1;
              err_q        <= 1'b1;
            end
            if (stop_w) begin
              pend_q  <= '0;
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ARB;
            end
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_src_o   = src_q;
  assign cmd_dst_o   = dst_q;
  assign cmd_len_o   = len_q;
  assign cmd_id_o    = id_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign desc_done_o = ddone_q;
  assign desc_err_o  = derr_q;

endmodule
